lms_weight_update: RTL and testbench
====================================

# lms_weight_update

Sequential LMS coefficient-update engine for the adaptive filter. It consumes the error word produced by the output/error stage, E = D − Y, and the input sample stream. Each accepted error updates every tap weight by w[k] += (e·x[k]) >>> (DW−1+MU_SHIFT). The engine uses one shared multiplier and processes one tap per cycle. The updated weights feed the filter's multiply/sum-carry array for the next output.

## Interface
- TAPS, 4, number of filter taps (≥2)
- DW, 10, sample and error width, signed two's complement
- WW, 10, weight width, signed two's complement
- MU_SHIFT, 3, step size μ = 2^−MU_SHIFT

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- x_valid  in  1  new input sample present
- x_in  in  DW  input sample
- x_ready  out  1  high when a sample can be accepted (= ~busy)
- err_valid  in  1  new error word present
- err_in  in  DW  error E from output/error stage
- busy  out  1  update sequence in progress
- upd_done  out  1  one-cycle pulse: all TAPS weights updated
- w_flat  out  TAPS*WW  weights, tap k at bits [k*WW +: WW]

## Operation
- Delay line x[0..TAPS−1]. On an accepted x_valid (x_valid & x_ready): x[0] ← x_in and x[k] ← x[k−1].
- FSM states:
  - IDLE: on err_valid, latch err_in, set idx=0, go to UPD. A sample shift in the same cycle is performed, and the update uses the shifted line.
  - UPD: one tap per cycle, idx 0..TAPS−1. After idx=TAPS−1, go to DONE.
  - DONE: upd_done=1 for one cycle, then go to IDLE.
- While busy (UPD or DONE), the delay line is frozen. x_valid and err_valid are ignored and dropped, with no queueing. The producer must respect x_ready.
- Per-tap arithmetic:
  - p = e·x[idx] as a full 2·DW-bit signed product.
  - delta = p >>> (DW−1+MU_SHIFT), arithmetic right shift, which floors toward −∞.
  - sum = w[idx] + delta, computed at WW+1 bits and then reduced to WW bits (see Configuration).
- Weights change only in UPD, one tap per cycle. The other taps hold.

## Timing
- Reset values: all weights 0, delay line 0, state IDLE, busy=0, upd_done=0, x_ready=1, w_flat=0.
- err_valid is sampled in cycle 0. Tap k is written at the end of cycle 1+k. upd_done is high in cycle TAPS+1. busy is high in cycles 1..TAPS+1, and x_ready is low in the same cycles.
- The earliest next accepted error is cycle TAPS+2. Throughput is one update per TAPS+2 cycles.
- w_flat is registered and reflects each tap write on the cycle after the write edge.
- Asserting rst_n low mid-sequence aborts the update immediately: weights, delay line and FSM return to reset values, and no upd_done pulse is produced.

## Configuration
- LMS_SATURATE_EN defined: sum is clamped to [−2^(WW−1), 2^(WW−1)−1].
- LMS_SATURATE_EN undefined: sum wraps modulo 2^WW, keeping the low WW bits.

## Structure
- Package lms_pkg holds:
  - state enum {IDLE, UPD, DONE};
  - default width constants DW_DEF=10, WW_DEF=10;
  - localparam SHIFT = DW−1+MU_SHIFT, computed in the module from its parameters.
- Sub-module lms_tap_update is combinational. Inputs are e, x and w_old; output is w_new. It contains the multiply, shift and add, plus the saturate/wrap selection. The top level contains the FSM, the index counter, the delay line and the weight registers.

## Test plan
All scenarios use TAPS=4, DW=10, WW=10, MU_SHIFT=3.
- Reset: rst_n=0 → w_flat=0, busy=0, x_ready=1, upd_done=0.
- Basic update:
  - Stimulus: shift x=256 once, then err_valid with e=256.
  - Required: w[0]=16 and w[1..3]=0.
  - Required: upd_done is high exactly in cycle 5 after err_valid, and busy is high in cycles 1–5.
- Negative and floor:
  - Stimulus: x=256 with e=−256.
  - Required: w[0]=−16.
  - Stimulus: x=1 with e=1, starting from w=0.
  - Required: delta=0 and w[0] unchanged; x=−1 with e=1 gives delta=−1.
- Saturation:
  - Stimulus: x=511 in line slot 0, then e=511 nine times.
  - Required: w[0] is 504 after 8 updates.
  - Required: after the 9th update, w[0]=511 with LMS_SATURATE_EN, or −457 without it.
- Busy drops:
  - Stimulus: assert x_valid and err_valid during cycles 1–5 of an update.
  - Required: the delay line and the latched error are unchanged, and exactly one upd_done pulse is produced.
- Mid-sequence reset:
  - Stimulus: pull rst_n low in cycle 2 of an update.
  - Required: all weights return to 0, state is IDLE, and no upd_done pulse occurs.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared types and default widths for the LMS coefficient-update engine.
package lms_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        DONE = 2'd2
    } lms_state_e;

    localparam int DW_DEF = 10;
    localparam int WW_DEF = 10;

endpackage

// File: rtl/lms_tap_update.sv
// Combinational single-tap update: w_new = w_old + ((e*x) >>> (DW-1+MU_SHIFT)).
// LMS_SATURATE_EN selects clamping of the sum; otherwise the sum wraps to WW bits.
module lms_tap_update
    import lms_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int WW       = WW_DEF,
    parameter int MU_SHIFT = 3
) (
    input  logic signed [DW-1:0] e,
    input  logic signed [DW-1:0] x,
    input  logic signed [WW-1:0] w_old,
    output logic signed [WW-1:0] w_new
);

    localparam int SHIFT = DW - 1 + MU_SHIFT;

    logic signed [2*DW-1:0] p;
    logic signed [2*DW-1:0] delta;
    logic signed [WW:0]     delta_w;
    logic signed [WW:0]     sum;

    always_comb begin
        p       = e * x;
        // Arithmetic shift floors toward minus infinity, so tiny negative products give -1.
        delta   = p >>> SHIFT;
        delta_w = (WW+1)'(delta);
        sum     = (WW+1)'(w_old) + delta_w;
`ifdef LMS_SATURATE_EN
        if (sum[WW] != sum[WW-1]) begin
            w_new = sum[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
        end else begin
            w_new = sum[WW-1:0];
        end
`else
        w_new = sum[WW-1:0];
`endif
    end

endmodule

// File: rtl/lms_weight_update.sv
// Sequential LMS weight-update engine: one shared tap datapath, one tap per cycle.
// Optional clamping of updated weights is enabled by defining LMS_SATURATE_EN.
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int TAPS     = 4,
    parameter int DW       = DW_DEF,
    parameter int WW       = WW_DEF,
    parameter int MU_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x_valid,
    input  logic [DW-1:0]        x_in,
    output logic                 x_ready,
    input  logic                 err_valid,
    input  logic [DW-1:0]        err_in,
    output logic                 busy,
    output logic                 upd_done,
    output logic [TAPS*WW-1:0]   w_flat
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    // Handshake: a sample moves in on a clock edge where x_valid && x_ready; an error
    // starts an update on an edge where err_valid is high in IDLE. Anything offered
    // while busy is dropped, not queued.

    lms_state_e          state_q;
    logic [IW-1:0]       idx_q;
    logic                busy_q;
    logic                upd_done_q;
    logic signed [DW-1:0] e_q;

    logic signed [DW-1:0] x_q [TAPS];
    logic signed [DW-1:0] x_d [TAPS];
    logic [TAPS*WW-1:0]   w_q;
    logic [TAPS*WW-1:0]   w_d;

    logic signed [DW-1:0] x_sel;
    logic signed [WW-1:0] w_sel;
    logic signed [WW-1:0] w_new;

    assign x_ready  = ~busy_q;
    assign busy     = busy_q;
    assign upd_done = upd_done_q;
    assign w_flat   = w_q;

    always_comb begin
        x_sel = x_q[idx_q];
        w_sel = w_q[int'(idx_q)*WW +: WW];
    end

    lms_tap_update #(
        .DW       (DW),
        .WW       (WW),
        .MU_SHIFT (MU_SHIFT)
    ) u_tap (
        .e     (e_q),
        .x     (x_sel),
        .w_old (w_sel),
        .w_new (w_new)
    );

    always_comb begin
        x_d = x_q;
        if (x_valid && !busy_q) begin
            x_d[0] = x_in;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
        w_d = w_q;
        if (state_q == UPD) begin
            w_d[int'(idx_q)*WW +: WW] = w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            w_q <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= x_d[k];
            end
            w_q <= w_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            upd_done_q <= 1'b0;
            e_q        <= '0;
        end else begin
            upd_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (err_valid) begin
                        e_q     <= err_in;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= UPD;
                    end
                end
                UPD: begin
                    if (idx_q == IW'(TAPS-1)) begin
                        upd_done_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update (TAPS=4, DW=10, WW=10, MU_SHIFT=3).
// Expected saturation result depends on LMS_SATURATE_EN.
module tb_lms_weight_update;

    localparam int TAPS = 4;
    localparam int DW   = 10;
    localparam int WW   = 10;

    logic                clk;
    logic                rst_n;
    logic                x_valid;
    logic [DW-1:0]       x_in;
    logic                x_ready;
    logic                err_valid;
    logic [DW-1:0]       err_in;
    logic                busy;
    logic                upd_done;
    logic [TAPS*WW-1:0]  w_flat;

    int n_cmp = 0;
    int n_err = 0;

    lms_weight_update #(
        .TAPS(TAPS), .DW(DW), .WW(WW), .MU_SHIFT(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x_in      (x_in),
        .x_ready   (x_ready),
        .err_valid (err_valid),
        .err_in    (err_in),
        .busy      (busy),
        .upd_done  (upd_done),
        .w_flat    (w_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] e;
        logic signed [WW-1:0] w0;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TAPS*WW-1:0] pack(input logic signed [WW-1:0] w0,
                                                 input logic signed [WW-1:0] w1,
                                                 input logic signed [WW-1:0] w2,
                                                 input logic signed [WW-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic do_reset();
        x_valid = 1'b0; x_in = '0; err_valid = 1'b0; err_in = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic shift_x(input logic signed [DW-1:0] v);
        x_valid = 1'b1;
        x_in    = v;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    // Drives err in cycle 0 and records busy/upd_done for cycles 0..7.
    task automatic run_update(input logic signed [DW-1:0] e, input bit drop,
                              output logic [7:0] busy_m, output logic [7:0] upd_m);
        err_in    = e;
        err_valid = 1'b1;
        busy_m[0] = busy;
        upd_m[0]  = upd_done;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            err_valid = 1'b0;
            x_valid   = 1'b0;
            if (drop && c <= 5) begin
                err_valid = 1'b1;
                err_in    = -10'sd300;
                x_valid   = 1'b1;
                x_in      = 10'sd100;
            end
            busy_m[c] = busy;
            upd_m[c]  = upd_done;
        end
        err_valid = 1'b0;
        x_valid   = 1'b0;
    endtask

    logic [7:0] bm, um;
    logic [7:0] upd_seen;

    initial begin
        vecs[0] = '{x:  10'sd256, e:  10'sd256, w0:  10'sd16};
        vecs[1] = '{x:  10'sd256, e: -10'sd256, w0: -10'sd16};
        vecs[2] = '{x:  10'sd1,   e:  10'sd1,   w0:  10'sd0};
        vecs[3] = '{x: -10'sd1,   e:  10'sd1,   w0: -10'sd1};
        vecs[4] = '{x: -10'sd256, e: -10'sd256, w0:  10'sd16};
        vecs[5] = '{x:  10'sd511, e:  10'sd511, w0:  10'sd63};
        vecs[6] = '{x: -10'sd512, e: -10'sd512, w0:  10'sd64};
        vecs[7] = '{x:  10'sd100, e: -10'sd37,  w0: -10'sd1};

        rst_n = 1'b1;
        do_reset();
        check("reset_w_flat",   64'(w_flat),   64'd0);
        check("reset_busy",     64'(busy),     64'd0);
        check("reset_x_ready",  64'(x_ready),  64'd1);
        check("reset_upd_done", 64'(upd_done), 64'd0);

        // Table: single update from reset, only tap 0 sees a nonzero sample.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            shift_x(vecs[i].x);
            run_update(vecs[i].e, 1'b0, bm, um);
            check($sformatf("vec%0d_w_flat", i), 64'(w_flat),
                  64'(pack(vecs[i].w0, 10'sd0, 10'sd0, 10'sd0)));
            if (i == 0) begin
                check("basic_busy_cycles",  64'(bm), 64'b0011_1110);
                check("basic_upd_cycle",    64'(um), 64'b0010_0000);
            end
        end

        // Two samples in the line: x[0]=128, x[1]=256, e=256 -> w0=8, w1=16.
        do_reset();
        shift_x(10'sd256);
        shift_x(10'sd128);
        run_update(10'sd256, 1'b0, bm, um);
        check("two_tap_w_flat", 64'(w_flat), 64'(pack(10'sd8, 10'sd16, 10'sd0, 10'sd0)));

        // Accumulate toward saturation: +63 per update.
        do_reset();
        shift_x(10'sd511);
        for (int n = 0; n < 8; n++) begin
            run_update(10'sd511, 1'b0, bm, um);
        end
        check("sat_after_8", 64'(w_flat), 64'(pack(10'sd504, 10'sd0, 10'sd0, 10'sd0)));
        run_update(10'sd511, 1'b0, bm, um);
`ifdef LMS_SATURATE_EN
        check("sat_after_9", 64'(w_flat), 64'(pack(10'sd511, 10'sd0, 10'sd0, 10'sd0)));
`else
        check("wrap_after_9", 64'(w_flat), 64'(pack(-10'sd457, 10'sd0, 10'sd0, 10'sd0)));
`endif

        // Busy drops: traffic during cycles 1..5 must not touch line or latched error.
        do_reset();
        shift_x(10'sd256);
        run_update(10'sd256, 1'b1, bm, um);
        check("drop_w_flat",    64'(w_flat), 64'(pack(10'sd16, 10'sd0, 10'sd0, 10'sd0)));
        check("drop_upd_pulse", 64'(um),     64'b0010_0000);
        check("drop_busy",      64'(bm),     64'b0011_1110);
        run_update(10'sd256, 1'b0, bm, um);
        check("drop_line_kept", 64'(w_flat), 64'(pack(10'sd32, 10'sd0, 10'sd0, 10'sd0)));

        // Mid-sequence reset in cycle 2 of an update.
        do_reset();
        shift_x(10'sd256);
        err_in    = 10'sd256;
        err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_w0", 64'(w_flat), 64'(pack(10'sd16, 10'sd0, 10'sd0, 10'sd0)));
        rst_n = 1'b0;
        #1;
        check("midrst_w_flat",  64'(w_flat),   64'd0);
        check("midrst_busy",    64'(busy),     64'd0);
        check("midrst_x_ready", 64'(x_ready),  64'd1);
        upd_seen = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            upd_seen[c] = upd_done;
        end
        check("midrst_no_upd", 64'(upd_seen), 64'd0);
        run_update(10'sd256, 1'b0, bm, um);
        check("midrst_line_cleared", 64'(w_flat), 64'd0);
        check("midrst_next_upd",     64'(um),     64'b0010_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
